// File: rtl/layer_mem_arbiter.sv
// Two-master round-robin arbiter for the layer-memory port, with lock bursts capped at MAX_BURST.
// Latency: grant is combinational, the command issues 1 cycle later, and read data returns 2 cycles after the grant. Backpressure: a master holds req until it sees gnt.
// Optional macro LAYER_ARB_SEL_CHECK_EN suppresses commands with an illegal sel and raises the sticky err flag.
module layer_mem_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 20,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_sel,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_sel,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t        state;
    logic          rr_ptr;
    logic [3:0]    burst_cnt;

    logic          own_hold;
    logic          g0;
    logic          g1;
    logic          gnt_any;
    logic          cmd_we;
    logic          cmd_lock;
    logic          cmd_sel_ok;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [2:0]    cmd_sel;
    logic          other_req;
    logic          cont_owner;
    logic [3:0]    next_cnt;
    logic          burst_hit;

    logic          rd_pend;
    logic          rd_id;
    logic          rd_rej;

    // An owner that drops req loses ownership, and the same cycle falls back to round-robin.
    always_comb begin
        own_hold   = (state == OWN0 && m0_req) || (state == OWN1 && m1_req);
        g0         = own_hold ? (state == OWN0) : (m0_req && (!m1_req || !rr_ptr));
        g1         = own_hold ? (state == OWN1) : (m1_req && (!m0_req || rr_ptr));
        gnt_any    = g0 || g1;
        cmd_we     = g1 ? m1_we    : m0_we;
        cmd_lock   = g1 ? m1_lock  : m0_lock;
        cmd_addr   = g1 ? m1_addr  : m0_addr;
        cmd_wdata  = g1 ? m1_wdata : m0_wdata;
        cmd_sel    = g1 ? m1_sel   : m0_sel;
        other_req  = g1 ? m0_req   : m1_req;
        cont_owner = (g0 && state == OWN0) || (g1 && state == OWN1);
        next_cnt   = (cont_owner ? burst_cnt : 4'd0) + {3'd0, other_req};
        burst_hit  = other_req && (next_cnt >= BURST_LIM);
    end

    assign m0_gnt = g0;
    assign m1_gnt = g1;

`ifdef LAYER_ARB_SEL_CHECK_EN
    assign cmd_sel_ok = !(cmd_sel == 3'd0 || cmd_sel == 3'd6 || cmd_sel == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= 1'b0;
        else if (gnt_any && !cmd_sel_ok)
            err <= 1'b1;
    end
`else
    assign cmd_sel_ok = 1'b1;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= 4'd0;
        end else if (gnt_any) begin
            rr_ptr <= g0;
            if (cmd_lock && !burst_hit) begin
                state     <= g1 ? OWN1 : OWN0;
                burst_cnt <= next_cnt;
            end else begin
                state     <= IDLE;
                burst_cnt <= 4'd0;
            end
        end else begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= '0;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
            rd_rej   <= 1'b0;
        end else begin
            crd     <= gnt_any && !cmd_we && cmd_sel_ok;
            cwr     <= gnt_any && cmd_we && cmd_sel_ok;
            rd_pend <= gnt_any && !cmd_we;
            rd_id   <= g1;
            rd_rej  <= !cmd_sel_ok;
            if (gnt_any && cmd_sel_ok) begin
                csel <= cmd_sel;
                if (cmd_we) begin
                    caddr_wr <= cmd_addr;
                    cdata_wr <= cmd_wdata;
                end else begin
                    caddr_rd <= cmd_addr;
                end
            end
        end
    end

    // Read data is captured at the end of the issue cycle and steered back to the issuing master.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= rd_pend && !rd_id;
            m1_rvalid <= rd_pend && rd_id;
            if (rd_pend && !rd_id)
                m0_rdata <= rd_rej ? '0 : cdata_rd;
            if (rd_pend && rd_id)
                m1_rdata <= rd_rej ? '0 : cdata_rd;
        end
    end

endmodule

// File: doc/layer_mem_arbiter.md
Name: layer_mem_arbiter

Overview:
- Shares the single layer-memory port (crd/caddr_rd/cdata_rd, cwr/caddr_wr/cdata_wr, csel) between two masters.
  - Master 0: convolution/pooling engine.
  - Master 1: host readback/debug dump.
- Round-robin arbitration, one transaction per cycle.
- Optional ownership lock so a master can run an uninterrupted burst, e.g. the 4-read 2x2 max-pool window.
- All memory-side signals are registered; read data is returned to the issuing master with a fixed 2-cycle latency.

Parameters:
- AW, 12, address width (64x64 layer map).
- DW, 20, data width (signed Q4.16 layer data).
- MAX_BURST, 8, maximum consecutive locked grants to one master while the other is requesting; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 transaction request; held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_lock  in  1  keep ownership after this grant.
- m0_addr  in  AW  address.
- m0_wdata  in  DW  write data.
- m0_sel  in  3  target memory select.
- m0_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  m0_rdata valid (registered).
- m0_rdata  out  DW  read data (registered).
- m1_*  same set as m0_*, for master 1.
- crd  out  1  memory read strobe.
- caddr_rd  out  AW  memory read address.
- cdata_rd  in  DW  memory read data, valid while crd is high.
- cwr  out  1  memory write strobe.
- caddr_wr  out  AW  memory write address.
- cdata_wr  out  DW  memory write data.
- csel  out  3  memory select.
- err  out  1  sticky illegal-select flag; only active with the optional feature.

Behaviour:
- Reset values (reset_n low, asynchronous): all outputs 0, ownership state IDLE, round-robin pointer = master 0 preferred, burst counter 0.
  - Any in-flight read is discarded: no rvalid after reset.
- Handshake:
  - mX_gnt is high in the cycle mX_req is high and mX is selected.
  - Command fields are sampled on that edge.
  - The master may present a new command next cycle with req still high.
  - req must not drop, and command fields must not change, while waiting for gnt.
  - At most one of m0_gnt/m1_gnt is high in any cycle.
- Issue: in cycle N+1 after a grant in cycle N:
  - Read: crd=1, caddr_rd=addr, csel=sel, cwr=0.
  - Write: cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
  - Strobes are one-cycle pulses.
  - Address, data and csel registers hold their last value when idle.
- Read return:
  - cdata_rd is captured at the end of cycle N+1.
  - mX_rvalid=1 and mX_rdata=cdata_rd in cycle N+2, for the master that was granted in N.
  - Back-to-back reads give back-to-back rvalid; ordering is preserved.
  - mX_rdata holds its value when rvalid is 0.
- Arbitration states:
  - IDLE: round-robin. When only one master requests, it wins. When both request, the master not granted last wins.
  - OWN0 / OWN1: entered when the granted request has lock=1.
    - The owner is granted whenever it requests.
    - The other master gets no grant.
    - Ownership is left when the owner is granted with lock=0, which returns to IDLE.
    - Ownership is also left when the owner drops req for one cycle; return to IDLE, with arbitration in that same cycle.
  - Burst limit:
    - The counter increments on each owner grant while the other master has req=1, and clears on an owner change or in IDLE.
    - When the counter reaches MAX_BURST, the state returns to IDLE and the owner becomes lowest priority.
    - The waiting master is granted next cycle.
- After each grant the round-robin pointer points at the non-granted master.
- With MAX_BURST=1, lock has no effect whenever the other master is waiting.
- Widths: the block does no arithmetic on data; fields pass through unmodified. The burst counter is 4 bits.

Optional Feature:
- Macro: LAYER_ARB_SEL_CHECK_EN.
- Defined:
  - A granted command with sel of 0, 6 or 7 is still granted but is not issued: no crd/cwr pulse.
  - err is set to 1 and stays set until reset.
  - A rejected read still returns mX_rvalid in cycle N+2, with mX_rdata=0.
- Undefined: err is tied to 0 and every sel value passes through to csel unchanged.

Test Plan:
- Single read: m0 read addr 0x041, memory returns 0x12345 → m0_gnt in cycle 0; crd=1 with caddr_rd=0x041 in cycle 1; m0_rvalid=1 with m0_rdata=0x12345 in cycle 2.
- Both masters request continuously, lock=0, for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; m0 goes first after reset.
- m0 lock burst of 4 reads (0x000,0x001,0x040,0x041, lock=1,1,1,0) while m1 requests → m0 receives 4 consecutive grants; m1 is granted in the cycle after the last m0 grant; 4 rvalids arrive in order.
- MAX_BURST=2, m0 holds lock=1 continuously with m1 waiting → pattern is m0,m0,m1,m0,m0,m1.
- Mixed writes: m1 write 0x0FFFF to addr 0x3FF with sel=3 → cwr=1, caddr_wr=0x3FF, cdata_wr=0x0FFFF, csel=3 one cycle after grant; crd stays 0.
- Reset mid-read: reset_n low in cycle N+1 of a read → all outputs 0, no rvalid after release, first post-reset grant goes to m0. With LAYER_ARB_SEL_CHECK_EN, a read with sel=7 gives no crd, m0_rvalid with rdata 0, and err=1.
